// File: rtl/video_pkg.sv
// video_pkg: arbitration modes, FSM state encoding and default widths for the video memory arbiter
package video_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 32;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant search starting at a pointer (round-robin) or at index 0 (fixed priority)
module rr_arbiter
    import video_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  arb_mode_t     mode,
    output logic [N-1:0]  grant
);

    logic [IW-1:0] w_base;
    logic [IW:0]   w_sum;
    logic          w_found;

    assign w_base = (mode == ARB_FIXED) ? '0 : start;

    // walk the channels from the base index with wrap-around; first requester wins
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, w_base} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N))
                w_sum = w_sum - (IW+1)'(N);
            if (!w_found && req[w_sum[IW-1:0]]) begin
                grant[w_sum[IW-1:0]] = 1'b1;
                w_found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_mem_arbiter.sv
// video_mem_arbiter: shares one single-port RAM between videocard clients with a 2-cycle read return
module video_mem_arbiter
    import video_pkg::*;
#(
    parameter int        WIDTH      = DEF_WIDTH,
    parameter int        ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int        CHANNELS   = 4,
    parameter arb_mode_t ARB_MODE   = ARB_RR
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS-1:0]            ch_req,
    input  logic [CHANNELS-1:0]            ch_wren,
    input  logic [CHANNELS-1:0]            ch_lock,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_address,
    input  logic [CHANNELS*WIDTH-1:0]      ch_data,
    output logic [CHANNELS-1:0]            ch_grant,
    output logic [CHANNELS-1:0]            ch_rvalid,
    output logic [WIDTH-1:0]               ch_q,
    output logic [ADDR_WIDTH-1:0]          mem_address,
    output logic [WIDTH-1:0]               mem_data,
    output logic                           mem_wren,
    input  logic [WIDTH-1:0]               mem_q
);

    localparam int            IW      = $clog2(CHANNELS);
    localparam logic [IW-1:0] LAST_CH = IW'(CHANNELS - 1);

    state_t        r_state;
    logic [IW-1:0] r_last_grant;
    logic          r_p1_valid;
    logic [IW-1:0] r_p1_id;
    logic          r_p2_valid;
    logic [IW-1:0] r_p2_id;

    logic [IW-1:0]       w_start;
    logic [IW-1:0]       w_gidx;
    logic [CHANNELS-1:0] w_arb_grant;
    logic                w_hold;
    logic                w_any;

    assign w_start = (r_last_grant == LAST_CH) ? '0 : r_last_grant + 1'b1;
    assign w_hold  = (r_state == ST_LOCKED) && ch_req[r_last_grant];

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .req   (ch_req),
        .start (w_start),
        .mode  (ARB_MODE),
        .grant (w_arb_grant)
    );

    // a still-requesting locked channel overrides the search; nothing is granted while reset is held
    always_comb begin
        ch_grant = w_arb_grant;
        if (w_hold) begin
            ch_grant               = '0;
            ch_grant[r_last_grant] = 1'b1;
        end
        if (!rst_n)
            ch_grant = '0;
    end

    assign w_any = |ch_grant;

    // index of the granted channel
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (ch_grant[i])
                w_gidx = IW'(i);
    end

    // FSM, grant pointer, registered RAM request and the in-flight read id/valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= LAST_CH;
            mem_address  <= '0;
            mem_data     <= '0;
            mem_wren     <= 1'b0;
            r_p1_valid   <= 1'b0;
            r_p1_id      <= '0;
            r_p2_valid   <= 1'b0;
            r_p2_id      <= '0;
        end else begin
            r_state    <= !w_any ? ST_IDLE : ch_lock[w_gidx] ? ST_LOCKED : ST_ACTIVE;
            mem_wren   <= w_any & ch_wren[w_gidx];
            r_p1_valid <= w_any & ~ch_wren[w_gidx];
            r_p1_id    <= w_gidx;
            r_p2_valid <= r_p1_valid;
            r_p2_id    <= r_p1_id;
            if (w_any) begin
                r_last_grant <= w_gidx;
                mem_address  <= ch_address[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
                mem_data     <= ch_data[int'(w_gidx)*WIDTH +: WIDTH];
            end
        end
    end

    // return the RAM output to the channel whose read reaches the end of the pipeline
    always_comb begin
        ch_rvalid          = '0;
        ch_rvalid[r_p2_id] = r_p2_valid;
    end

    assign ch_q = r_p2_valid ? mem_q : '0;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// tb_video_mem_arbiter: directed scenarios with a read-return scoreboard for the video memory arbiter
module tb_video_mem_arbiter;
    import video_pkg::*;

    localparam int CH = 4;
    localparam int W  = 32;
    localparam int AW = 32;

    typedef struct {
        int          due;
        int          ch;
        logic [31:0] data;
    } rd_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    ch_req, ch_wren, ch_lock;
    logic [CH*AW-1:0] ch_address;
    logic [CH*W-1:0]  ch_data;
    logic [CH-1:0]    ch_grant, ch_rvalid, ch_grant_fx, ch_rvalid_fx;
    logic [W-1:0]     ch_q, ch_q_fx, mem_data, mem_data_fx;
    logic [AW-1:0]    mem_address, mem_address_fx;
    logic             mem_wren, mem_wren_fx;
    logic [W-1:0]     mem_q = '0;
    logic [W-1:0]     mem_q_fx = '0;

    logic [31:0] ram [256];
    logic [31:0] exp_mem [256];
    rd_t         sb [$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    video_mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .CHANNELS(CH), .ARB_MODE(ARB_RR)) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_wren(ch_wren), .ch_lock(ch_lock),
        .ch_address(ch_address), .ch_data(ch_data), .ch_grant(ch_grant), .ch_rvalid(ch_rvalid),
        .ch_q(ch_q), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    video_mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .CHANNELS(CH), .ARB_MODE(ARB_FIXED)) dut_fx (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_wren(ch_wren), .ch_lock(ch_lock),
        .ch_address(ch_address), .ch_data(ch_data), .ch_grant(ch_grant_fx), .ch_rvalid(ch_rvalid_fx),
        .ch_q(ch_q_fx), .mem_address(mem_address_fx), .mem_data(mem_data_fx), .mem_wren(mem_wren_fx), .mem_q(mem_q_fx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM with one-cycle registered q
    always @(posedge clk) begin
        if (mem_wren)
            ram[mem_address[7:0]] <= mem_data;
        mem_q <= ram[mem_address[7:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // read returns: pop when due, otherwise no rvalid may be seen
    always @(negedge clk) begin
        rd_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            chk("rd_lost", 64'(sb[0].ch), 64'hFF);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rvalid", 64'(ch_rvalid), 64'(1) << e.ch);
            chk("ch_q", 64'(ch_q), 64'(e.data));
        end else
            chk("rvalid_idle", 64'(ch_rvalid), 64'h0);
    end

    // check the grant mid-cycle, record what the bench expects to be accepted, then cross the edge
    task automatic step(input string tag, input logic [3:0] exp_g, input logic fx_en, input logic [3:0] exp_fx);
        int  i;
        rd_t e;
        @(negedge clk);
        chk(tag, 64'(ch_grant), 64'(exp_g));
        if (fx_en)
            chk({tag, "_fx"}, 64'(ch_grant_fx), 64'(exp_fx));
        if (exp_g != 4'b0) begin
            i = $clog2(exp_g);
            if (ch_wren[i])
                exp_mem[ch_address[i*AW +: 8]] = ch_data[i*W +: W];
            else begin
                e.due  = cyc + 2;
                e.ch   = i;
                e.data = exp_mem[ch_address[i*AW +: 8]];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step("idle", 4'b0000, 1'b0, 4'b0000);
    endtask

    task automatic set_addr(input int i, input logic [31:0] a, input logic [31:0] d);
        ch_address[i*AW +: AW] = a;
        ch_data[i*W +: W]      = d;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant"}, 64'(ch_grant), 64'h0);
        chk({tag, "_grant_fx"}, 64'(ch_grant_fx), 64'h0);
        chk({tag, "_rvalid"}, 64'(ch_rvalid), 64'h0);
        chk({tag, "_q"}, 64'(ch_q), 64'h0);
        chk({tag, "_wren"}, 64'(mem_wren), 64'h0);
        chk({tag, "_addr"}, 64'(mem_address), 64'h0);
        chk({tag, "_data"}, 64'(mem_data), 64'h0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'hA500_0000 + i;
            exp_mem[i] = 32'hA500_0000 + i;
        end
        ram[8'h10]     = 32'hDEADBEEF;
        exp_mem[8'h10] = 32'hDEADBEEF;
        ch_req  = 4'b1111;
        ch_wren = 4'b0000;
        ch_lock = 4'b0000;
        for (int i = 0; i < CH; i++)
            set_addr(i, 32'h20 + i, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("rr0", 4'b0001, 1'b0, 4'b0);
        step("rr1", 4'b0010, 1'b0, 4'b0);
        step("rr2", 4'b0100, 1'b0, 4'b0);
        step("rr3", 4'b1000, 1'b0, 4'b0);
        step("rr4", 4'b0001, 1'b0, 4'b0);
        ch_req = 4'b0000;
        idle(3);
        ch_req = 4'b0010;
        set_addr(1, 32'h10, 32'h0);
        step("s_grant", 4'b0010, 1'b0, 4'b0);
        ch_req = 4'b0000;
        chk("s_maddr", 64'(mem_address), 64'h10);
        chk("s_mwren", 64'(mem_wren), 64'h0);
        idle(3);
        chk("hold_addr", 64'(mem_address), 64'h10);
        chk("hold_wren", 64'(mem_wren), 64'h0);
        ch_req  = 4'b0001;
        ch_wren = 4'b0001;
        set_addr(0, 32'h40, 32'h5A5A5A5A);
        step("wr", 4'b0001, 1'b0, 4'b0);
        ch_req  = 4'b0010;
        ch_wren = 4'b0000;
        set_addr(1, 32'h40, 32'h0);
        chk("wr_wren", 64'(mem_wren), 64'h1);
        chk("wr_addr", 64'(mem_address), 64'h40);
        chk("wr_data", 64'(mem_data), 64'h5A5A5A5A);
        step("rb", 4'b0010, 1'b0, 4'b0);
        ch_req = 4'b0000;
        chk("wr_once", 64'(mem_wren), 64'h0);
        idle(3);
        ch_req  = 4'b0101;
        ch_lock = 4'b0100;
        step("lk1", 4'b0100, 1'b0, 4'b0);
        step("lk2", 4'b0100, 1'b0, 4'b0);
        step("lk3", 4'b0100, 1'b0, 4'b0);
        ch_req  = 4'b0001;
        ch_lock = 4'b0000;
        step("lk_rel_ch0", 4'b0001, 1'b0, 4'b0);
        ch_req = 4'b0000;
        idle(1);
        ch_req  = 4'b1101;
        ch_lock = 4'b0100;
        step("lk2_1", 4'b0100, 1'b0, 4'b0);
        step("lk2_2", 4'b0100, 1'b0, 4'b0);
        step("lk2_3", 4'b0100, 1'b0, 4'b0);
        ch_req  = 4'b1001;
        ch_lock = 4'b0000;
        step("lk_rel_ch3", 4'b1000, 1'b0, 4'b0);
        ch_req = 4'b0000;
        idle(1);
        ch_req = 4'b1001;
        step("fx0", 4'b0001, 1'b1, 4'b0001);
        step("fx1", 4'b1000, 1'b1, 4'b0001);
        step("fx2", 4'b0001, 1'b1, 4'b0001);
        step("fx3", 4'b1000, 1'b1, 4'b0001);
        ch_req = 4'b0000;
        idle(3);
        ch_req = 4'b0100;
        step("mr", 4'b0100, 1'b0, 4'b0);
        rst_n  = 1'b0;
        sb.delete();
        ch_req = 4'b1111;
        #1;
        chk_reset("mr");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step("mr_first", 4'b0001, 1'b1, 4'b0001);
        ch_req = 4'b0000;
        idle(4);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
